// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter
// Shares the single data-memory port between the CPU load/store path and the
// CP2 DMA master. The DMA master requests the bus with a level HOLD and owns
// it while HOLD_ACK is high. The single-cycle CPU is stalled (PC frozen) for
// the whole tenure, including one turnaround cycle on each side.
//
// Each tenure lasts at most MAX_BURST cycles. After a release the CPU is
// guaranteed CPU_GAP+1 unstalled cycles before the next grant.
//
// Handshake: i_hold is a level request. The master may drive the bus only
// while o_hold_ack=1, and it keeps i_hold high until it is done. A drop of
// i_hold during a tenure ends it on the next edge. Every output decodes from
// registered state only, so i_hold has no combinational path to any output.
//
// Optional build macro ARB_STATS_EN adds two saturating 16-bit counters,
// o_grant_cnt and o_forced_rel_cnt.
module dmem_bus_arbiter #(
  parameter int MAX_BURST = 16,  // 1..255
  parameter int CPU_GAP   = 2    // 0..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_irq_pending,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wd,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wd,
  output logic        o_hold_ack,
  output logic        o_cpu_stall,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [1:0]  o_dbg_state
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] o_grant_cnt,
  output logic [15:0] o_forced_rel_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_DMA  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  localparam logic [7:0] LP_BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] LP_GAP_LOAD   = 8'(CPU_GAP);

  state_t     r_state;
  logic [7:0] r_burst_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_hold_ack;
  logic       r_cpu_stall;

  // The burst limit is reached on the last allowed DMA cycle.
  logic w_burst_last;
  assign w_burst_last = (r_burst_cnt == LP_BURST_LAST);

  // Arbitration FSM: state, counters and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= 8'd0;
      r_gap_cnt   <= 8'd0;
      r_hold_ack  <= 1'b0;
      r_cpu_stall <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_gap_cnt != 8'd0) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
          // The grant decision uses the registered gap count, so a request
          // that rises on the cycle the count reaches zero waits one cycle.
          if (i_hold && (r_gap_cnt == 8'd0) && !i_irq_pending) begin
            r_state     <= ST_ARB;
            r_cpu_stall <= 1'b1;
          end
        end
        ST_ARB: begin
          if (i_hold) begin
            r_state     <= ST_DMA;
            r_burst_cnt <= 8'd0;
            r_hold_ack  <= 1'b1;
          end else begin
            // The request was withdrawn during turnaround, so the CPU
            // resumes at once.
            r_state     <= ST_IDLE;
            r_cpu_stall <= 1'b0;
          end
        end
        ST_DMA: begin
          r_burst_cnt <= r_burst_cnt + 8'd1;
          if (!i_hold || w_burst_last) begin
            r_state    <= ST_REL;
            r_hold_ack <= 1'b0;
          end
        end
        ST_REL: begin
          r_gap_cnt   <= LP_GAP_LOAD;
          r_state     <= ST_IDLE;
          r_cpu_stall <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hold_ack  <= 1'b0;
          r_cpu_stall <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux: the CPU owns the port in IDLE and the DMA master owns
  // it in DMA. Writes are blocked during both turnaround cycles.
  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_addr = i_cpu_addr;
    o_mem_wd   = i_cpu_wd;
    case (r_state)
      ST_IDLE: o_mem_we = i_cpu_we;
      ST_DMA: begin
        o_mem_we   = i_dma_we;
        o_mem_addr = i_dma_addr;
        o_mem_wd   = i_dma_wd;
      end
      default: o_mem_we = 1'b0;
    endcase
  end

  assign o_hold_ack  = r_hold_ack;
  assign o_cpu_stall = r_cpu_stall;
  assign o_dbg_state = r_state;

`ifdef ARB_STATS_EN
  logic [15:0] r_grant_cnt;
  logic [15:0] r_forced_rel_cnt;
  logic        w_grant_evt;
  logic        w_forced_evt;

  // A grant is the ARB to DMA step. A forced release is a burst-limit exit
  // taken while the master still requests the bus.
  assign w_grant_evt  = (r_state == ST_ARB) && i_hold;
  assign w_forced_evt = (r_state == ST_DMA) && i_hold && w_burst_last;

  // Saturating usage counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt      <= 16'd0;
      r_forced_rel_cnt <= 16'd0;
    end else begin
      if (w_grant_evt && (r_grant_cnt != 16'hFFFF)) begin
        r_grant_cnt <= r_grant_cnt + 16'd1;
      end
      if (w_forced_evt && (r_forced_rel_cnt != 16'hFFFF)) begin
        r_forced_rel_cnt <= r_forced_rel_cnt + 16'd1;
      end
    end
  end

  assign o_grant_cnt      = r_grant_cnt;
  assign o_forced_rel_cnt = r_forced_rel_cnt;
`endif

endmodule
